pipe_rip_add: RTL and testbench

PIPE_RIP_ADD -- requirements
Module: pipe_rip_add

---
 rtl/pipe_rip_add.sv | 114 +++++++++++
 tb/tb_pipe_rip_add.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_rip_add.sv
`default_nettype none
//==============================================================================
// Module      : pipe_rip_add
// Description : Pipelined ripple adder/subtractor with a valid/ready handshake.
//               Each stage adds one WIDTH/STAGES-bit slice.
// Revision    : 1.0 - initial release
//==============================================================================
module pipe_rip_add #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int SW = WIDTH / STAGES;

    // Stage registers: operands travel with the partial sum so later stages
    // still see the upper slices they have yet to add.
    logic [WIDTH-1:0]  r_a [STAGES];
    logic [WIDTH-1:0]  r_b [STAGES];
    logic [WIDTH-1:0]  r_s [STAGES];
    logic [STAGES-1:0] r_c;
    logic [STAGES-1:0] r_v;
    logic              r_ovf;

    logic [WIDTH-1:0]  w_a_in  [STAGES];
    logic [WIDTH-1:0]  w_b_in  [STAGES];
    logic [WIDTH-1:0]  w_s_in  [STAGES];
    logic [WIDTH-1:0]  w_s_nxt [STAGES];
    logic [SW:0]       w_slice [STAGES];
    logic [STAGES-1:0] w_c_in;
    logic [STAGES-1:0] w_v_in;
    logic [STAGES-1:0] w_c_nxt;
    logic              w_ovf_nxt;
    logic              w_en;

    // One global enable: the whole pipe moves together, so bubbles are kept.
    assign w_en     = out_ready | ~r_v[STAGES-1];
    assign in_ready = w_en;

    always_comb begin
        // Subtraction is a + ~b + 1; the forced carry replaces c_in.
        w_a_in[0] = a;
        w_b_in[0] = sub ? ~b : b;
        w_c_in[0] = sub | c_in;
        w_s_in[0] = '0;
        w_v_in[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_a_in[k] = r_a[k-1];
            w_b_in[k] = r_b[k-1];
            w_s_in[k] = r_s[k-1];
            w_c_in[k] = r_c[k-1];
            w_v_in[k] = r_v[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_slice[k] = {1'b0, w_a_in[k][k*SW +: SW]}
                       + {1'b0, w_b_in[k][k*SW +: SW]}
                       + {{SW{1'b0}}, w_c_in[k]};
            w_s_nxt[k] = w_s_in[k];
            w_s_nxt[k][k*SW +: SW] = w_slice[k][SW-1:0];
            w_c_nxt[k] = w_slice[k][SW];
        end
        // a^b^sum at the MSB recovers the carry into the MSB.
        w_ovf_nxt = w_a_in[STAGES-1][WIDTH-1] ^ w_b_in[STAGES-1][WIDTH-1]
                  ^ w_s_nxt[STAGES-1][WIDTH-1] ^ w_c_nxt[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v   <= '0;
            r_c   <= '0;
            r_ovf <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
        end else if (w_en) begin
            r_v <= w_v_in;
            // Data only loads behind a valid token, so bubble operands never
            // reach the outputs.
            for (int k = 0; k < STAGES; k++) begin
                if (w_v_in[k]) begin
                    r_a[k] <= w_a_in[k];
                    r_b[k] <= w_b_in[k];
                    r_s[k] <= w_s_nxt[k];
                    r_c[k] <= w_c_nxt[k];
                end
            end
            if (w_v_in[STAGES-1]) begin
                r_ovf <= w_ovf_nxt;
            end
        end
    end

    assign out_valid = r_v[STAGES-1];
    assign sum       = r_s[STAGES-1];
    assign c_out     = r_c[STAGES-1];
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipe_rip_add.sv
`default_nettype none
//==============================================================================
// Module      : tb_pipe_rip_add
// Description : Self-checking bench for pipe_rip_add (vectors + queue model).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_pipe_rip_add;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             c_in = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    always #5 clk = ~clk;

    pipe_rip_add #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .c_out    (c_out),
        .ovf      (ovf)
    );

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             c_in;
        logic             sub;
        logic [WIDTH-1:0] sum;
        logic             c_out;
        logic             ovf;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             c_out;
        logic             ovf;
        int               left;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];
    int   pushed = 0;
    int   popped = 0;
    logic m_ov;
    logic m_en;
    exp_t m_e;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic from plain integer math.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci, input logic s);
        exp_t e;
        int ux, uy, ur, sx, sy, sr;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            ur = ux - uy;
            sr = sx - sy;
            e.c_out = (ux >= uy);
        end else begin
            ur = ux + uy + int'(ci);
            sr = sx + sy + int'(ci);
            e.c_out = (ur >= (1 << WIDTH));
        end
        e.sum  = ur[WIDTH-1:0];
        e.ovf  = (sr >= (1 << (WIDTH-1))) || (sr < -(1 << (WIDTH-1)));
        e.left = STAGES - 1;
        return e;
    endfunction

    // Cycle-accurate queue model: every token counts down enabled cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            pushed = 0;
            popped = 0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_sum", sum, 0);
            chk("rst_in_ready", in_ready, 1);
        end else begin
            m_ov = (q.size() > 0) && (q[0].left == 0);
            m_en = out_ready || !m_ov;
            chk("mdl_out_valid", out_valid, m_ov);
            chk("mdl_in_ready", in_ready, m_en);
            if (m_ov) begin
                chk("mdl_sum", sum, q[0].sum);
                chk("mdl_c_out", c_out, q[0].c_out);
                chk("mdl_ovf", ovf, q[0].ovf);
                if (out_ready) begin
                    m_e = q.pop_front();
                    popped++;
                end
            end
            if (m_en) begin
                foreach (q[i]) q[i].left--;
                if (in_valid) begin
                    q.push_back(model(a, b, c_in, sub));
                    pushed++;
                end
            end
        end
    end

    task automatic scramble();
        a    = 16'($urandom);
        b    = 16'($urandom);
        c_in = 1'($urandom);
        sub  = 1'($urandom);
    endtask

    task automatic send_one(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                            input logic tc, input logic ts, output int lat);
        @(posedge clk); #1;
        in_valid = 1'b1; a = ta; b = tb; c_in = tc; sub = ts; out_ready = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            scramble();
            lat++;
        end while (!out_valid && lat < 10);
    endtask

    initial begin
        int   lat, nout;
        logic st;
        exp_t e;
        exp_t ex[8];
        exp_t tq[$];

        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[6] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[7] = '{16'h7FFF, 16'hFFFF, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1};

        // Reset state, with valid input and no downstream ready.
        in_valid = 1'b1;
        scramble();
        repeat (3) @(posedge clk);
        #2;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_sum", sum, 0);
        chk("reset_c_out", c_out, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;

        // Directed vectors, one at a time.
        for (int i = 0; i < 8; i++) begin
            send_one(tbl[i].a, tbl[i].b, tbl[i].c_in, tbl[i].sub, lat);
            chk($sformatf("vec%0d_latency", i), lat, STAGES);
            chk($sformatf("vec%0d_sum", i), sum, tbl[i].sum);
            chk($sformatf("vec%0d_c_out", i), c_out, tbl[i].c_out);
            chk($sformatf("vec%0d_ovf", i), ovf, tbl[i].ovf);
        end

        // Eight back-to-back transfers; results on cycles 4..11.
        nout = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            in_valid  = (c < 8);
            scramble();
            if (c < 8) ex[c] = model(a, b, c_in, sub);
            if (out_valid) begin
                if (nout < 8) begin
                    chk("b2b_cycle", c, nout + STAGES);
                    chk("b2b_sum", sum, ex[nout].sum);
                    chk("b2b_c_out", c_out, ex[nout].c_out);
                    chk("b2b_ovf", ovf, ex[nout].ovf);
                end
                nout++;
            end
        end
        chk("b2b_count", nout, 8);

        // Stall for 3 cycles with a bubble right behind the stalled result.
        nout = 0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            st        = (c >= 5 && c <= 7);
            out_ready = !st;
            in_valid  = (c < 10) && (c != 2);
            scramble();
            #1;
            if (st) begin
                chk("stall_in_ready", in_ready, 0);
                chk("stall_out_valid", out_valid, 1);
                if (tq.size() > 0) begin
                    chk("stall_sum_frozen", sum, tq[0].sum);
                    chk("stall_c_out_frozen", c_out, tq[0].c_out);
                    chk("stall_ovf_frozen", ovf, tq[0].ovf);
                end else begin
                    chk("stall_head_present", 0, 1);
                end
            end
            if (c == 9) chk("bubble_kept", out_valid, 0);
            if (out_valid && out_ready) begin
                if (tq.size() == 0) begin
                    chk("stall_extra_result", 1, 0);
                end else begin
                    e = tq.pop_front();
                    chk("stall_sum", sum, e.sum);
                    chk("stall_c_out", c_out, e.c_out);
                    chk("stall_ovf", ovf, e.ovf);
                    nout++;
                end
            end
            if (in_valid && !st) tq.push_back(model(a, b, c_in, sub));
        end
        chk("stall_count", nout, 6);

        // Reset with three transactions in flight.
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            in_valid = (c < 3);
            scramble();
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        chk("pre_reset_out_valid", out_valid, 1);
        rst_n = 1'b0; out_ready = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_c_out", c_out, 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("no_stale_result", out_valid, 0);
        end
        e = model(16'h00FF, 16'h0F01, 1'b1, 1'b0);
        send_one(16'h00FF, 16'h0F01, 1'b1, 1'b0, lat);
        chk("post_reset_latency", lat, STAGES);
        chk("post_reset_sum", sum, e.sum);

        // Random traffic with random back-pressure; the queue model checks it.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            scramble();
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 0);
        chk("pushed_vs_popped", popped, pushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
